// File: rtl/decodificador_prioridade_seq.sv
// decodificador_prioridade_seq
// Sequential 4-to-16 one-hot decoder with a valid/ready input handshake.
// An accepted non-zero code k drives out[k] for HOLD_CYCLES cycles. A guard
// gap of GAP_CYCLES idle cycles follows. Normal completion gives a one-cycle
// done strobe.
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   code         priority code to decode (0 = no request)
//   valid_in     code is valid this cycle
//   ready_in     block can accept a code (IDLE only, decoded from state)
//   abort        synchronous cancel of the current pulse or gap
//   out          registered one-hot output, out[0] never driven
//   active_code  code currently being driven, 0 when idle
//   done         one-cycle strobe at normal pulse completion
module decodificador_prioridade_seq #(
    parameter int unsigned HOLD_CYCLES = 4,  // legal range 1..256
    parameter int unsigned GAP_CYCLES  = 1   // legal range 0..256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  code,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic        abort,
    output logic [15:0] out,
    output logic [3:0]  active_code,
    output logic        done
);

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StGap
    } state_e;

    localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES - 1);
    // Guarded so GAP_CYCLES = 0 does not underflow; the value is unused then.
    localparam logic [7:0] GapLoad  = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] out_q, out_d;
    logic [3:0]  code_q, code_d;
    logic        done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        code_d  = code_q;
        done_d  = 1'b0;

        if (abort) begin
            // Abort beats everything, including a same-cycle accept.
            state_d = StIdle;
            cnt_d   = 8'd0;
            out_d   = 16'h0000;
            code_d  = 4'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    out_d  = 16'h0000;
                    code_d = 4'd0;
                    // Code 0 is accepted but discarded: stay idle.
                    if (valid_in && (code != 4'd0)) begin
                        out_d   = 16'b1 << code;
                        code_d  = code;
                        cnt_d   = HoldLoad;
                        state_d = StHold;
                    end
                end
                StHold: begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        out_d  = 16'h0000;
                        code_d = 4'd0;
                        done_d = 1'b1;
                        if (GAP_CYCLES == 0) begin
                            state_d = StIdle;
                        end else begin
                            cnt_d   = GapLoad;
                            state_d = StGap;
                        end
                    end
                end
                StGap: begin
                    out_d = 16'h0000;
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                    out_d   = 16'h0000;
                    code_d  = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            out_q   <= 16'h0000;
            code_q  <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            code_q  <= code_d;
            done_q  <= done_d;
        end
    end

    // Decoded from the state register only, so it follows rst_n immediately.
    assign ready_in    = (state_q == StIdle);
    assign out         = out_q;
    assign active_code = code_q;
    assign done        = done_q;

endmodule

// File: tb/tb_decodificador_prioridade_seq.sv
module tb_decodificador_prioridade_seq;

    logic clk;
    logic rst_n;

    // DUT A: defaults (HOLD 4, GAP 1)
    logic [3:0]  code_a;
    logic        valid_a, abort_a, ready_a, done_a;
    logic [15:0] out_a;
    logic [3:0]  act_a;

    // DUT B: HOLD 1, GAP 0
    logic [3:0]  code_b;
    logic        valid_b, abort_b, ready_b, done_b;
    logic [15:0] out_b;
    logic [3:0]  act_b;

    // DUT C: HOLD 256 (counter boundary), GAP 1
    logic [3:0]  code_c;
    logic        valid_c, abort_c, ready_c, done_c;
    logic [15:0] out_c;
    logic [3:0]  act_c;

    int tests;
    int fails;

    decodificador_prioridade_seq dut_a (
        .clk(clk), .rst_n(rst_n), .code(code_a), .valid_in(valid_a), .ready_in(ready_a),
        .abort(abort_a), .out(out_a), .active_code(act_a), .done(done_a)
    );

    decodificador_prioridade_seq #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .code(code_b), .valid_in(valid_b), .ready_in(ready_b),
        .abort(abort_b), .out(out_b), .active_code(act_b), .done(done_b)
    );

    decodificador_prioridade_seq #(.HOLD_CYCLES(256), .GAP_CYCLES(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .code(code_c), .valid_in(valid_c), .ready_in(ready_c),
        .abort(abort_c), .out(out_c), .active_code(act_c), .done(done_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (ready_a !== 1'b1) begin fails++; $display("FAIL rst_ready got=%b exp=1", ready_a); end
        tests++; if (out_a !== 16'h0000) begin fails++; $display("FAIL rst_out got=%h exp=0000", out_a); end
        tests++; if (act_a !== 4'h0) begin fails++; $display("FAIL rst_active got=%h exp=0", act_a); end
        tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL rst_done got=%b exp=0", done_a); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_pulse();
        code_a = 4'hA; valid_a = 1'b1;
        @(negedge clk);                 // E0 just happened
        valid_a = 1'b0; code_a = 4'h0;
        for (int i = 0; i < 4; i++) begin
            tests++; if (out_a !== 16'h0400) begin fails++; $display("FAIL pulse_out[%0d] got=%h exp=0400", i, out_a); end
            tests++; if (act_a !== 4'hA) begin fails++; $display("FAIL pulse_active[%0d] got=%h exp=a", i, act_a); end
            tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL pulse_done_early[%0d] got=%b exp=0", i, done_a); end
            tests++; if (ready_a !== 1'b0) begin fails++; $display("FAIL pulse_ready[%0d] got=%b exp=0", i, ready_a); end
            @(negedge clk);
        end
        // After E4: first cycle of out=0, done strobe, still in gap
        tests++; if (out_a !== 16'h0000) begin fails++; $display("FAIL pulse_out_end got=%h exp=0000", out_a); end
        tests++; if (done_a !== 1'b1) begin fails++; $display("FAIL pulse_done got=%b exp=1", done_a); end
        tests++; if (ready_a !== 1'b0) begin fails++; $display("FAIL pulse_gap_ready got=%b exp=0", ready_a); end
        tests++; if (act_a !== 4'h0) begin fails++; $display("FAIL pulse_active_end got=%h exp=0", act_a); end
        @(negedge clk);
        tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL pulse_done_width got=%b exp=0", done_a); end
        tests++; if (ready_a !== 1'b1) begin fails++; $display("FAIL pulse_ready_back got=%b exp=1", ready_a); end
    endtask

    task automatic test_back_to_back();
        int k, accepts, dones, bad0, cyc, last;
        logic take;
        logic [15:0] exp_out;
        k = 1; accepts = 0; dones = 0; bad0 = 0; cyc = 0; last = -1;
        code_a = 4'(k); valid_a = 1'b1;
        while (accepts < 15 && cyc < 200) begin
            take = ready_a;             // accept happens on the coming edge
            @(negedge clk);
            cyc++;
            if (done_a) dones++;
            if (out_a[0]) bad0++;
            if (take) begin
                exp_out = 16'b1 << k;
                tests++; if (out_a !== exp_out) begin fails++; $display("FAIL b2b_out k=%0d got=%h exp=%h", k, out_a, exp_out); end
                tests++; if (act_a !== 4'(k)) begin fails++; $display("FAIL b2b_active k=%0d got=%h exp=%h", k, act_a, 4'(k)); end
                if (last >= 0) begin
                    tests++; if (cyc - last !== 6) begin fails++; $display("FAIL b2b_interval k=%0d got=%0d exp=6", k, cyc - last); end
                end
                last = cyc;
                accepts++;
                k++;
                code_a = 4'(k);
            end
        end
        valid_a = 1'b0; code_a = 4'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_a) dones++;
            if (out_a[0]) bad0++;
        end
        tests++; if (accepts !== 15) begin fails++; $display("FAIL b2b_accepts got=%0d exp=15", accepts); end
        tests++; if (dones !== 15) begin fails++; $display("FAIL b2b_dones got=%0d exp=15", dones); end
        tests++; if (bad0 !== 0) begin fails++; $display("FAIL b2b_out0 got=%0d exp=0", bad0); end
    endtask

    task automatic test_code_zero();
        code_a = 4'h0; valid_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++; if (out_a !== 16'h0000) begin fails++; $display("FAIL zero_out[%0d] got=%h exp=0000", i, out_a); end
            tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL zero_done[%0d] got=%b exp=0", i, done_a); end
            tests++; if (ready_a !== 1'b1) begin fails++; $display("FAIL zero_ready[%0d] got=%b exp=1", i, ready_a); end
        end
        valid_a = 1'b0;
    endtask

    task automatic test_abort();
        code_a = 4'hF; valid_a = 1'b1;
        @(negedge clk);                 // after E0
        code_a = 4'h3;                  // upstream presents 3 while busy
        tests++; if (out_a !== 16'h8000) begin fails++; $display("FAIL abort_hold1 got=%h exp=8000", out_a); end
        @(negedge clk);                 // after E1, second hold cycle
        tests++; if (out_a !== 16'h8000) begin fails++; $display("FAIL abort_hold2 got=%h exp=8000", out_a); end
        abort_a = 1'b1;
        @(negedge clk);                 // after abort edge
        abort_a = 1'b0; valid_a = 1'b0;
        tests++; if (out_a !== 16'h0000) begin fails++; $display("FAIL abort_out got=%h exp=0000", out_a); end
        tests++; if (ready_a !== 1'b1) begin fails++; $display("FAIL abort_ready got=%b exp=1", ready_a); end
        tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL abort_done got=%b exp=0", done_a); end
        tests++; if (act_a !== 4'h0) begin fails++; $display("FAIL abort_active got=%h exp=0", act_a); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests++; if (out_a !== 16'h0000 || done_a !== 1'b0) begin
                fails++; $display("FAIL abort_quiet[%0d] out=%h done=%b exp out=0000 done=0", i, out_a, done_a);
            end
        end
    endtask

    task automatic test_gap_zero();
        code_b = 4'h5; valid_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++; if (out_b !== 16'h0020) begin fails++; $display("FAIL gap0_out[%0d] got=%h exp=0020", i, out_b); end
            tests++; if (ready_b !== 1'b0) begin fails++; $display("FAIL gap0_busy[%0d] got=%b exp=0", i, ready_b); end
            @(negedge clk);
            if (i == 2) valid_b = 1'b0;
            tests++; if (out_b !== 16'h0000) begin fails++; $display("FAIL gap0_low[%0d] got=%h exp=0000", i, out_b); end
            tests++; if (done_b !== 1'b1 || ready_b !== 1'b1) begin
                fails++; $display("FAIL gap0_done_ready[%0d] done=%b ready=%b exp 1 1", i, done_b, ready_b);
            end
        end
        @(negedge clk);
        tests++; if (out_b !== 16'h0000 || done_b !== 1'b0) begin
            fails++; $display("FAIL gap0_idle out=%h done=%b exp out=0000 done=0", out_b, done_b);
        end
    endtask

    task automatic test_hold_256();
        int hc;
        code_c = 4'h1; valid_c = 1'b1;
        @(negedge clk);
        valid_c = 1'b0;
        hc = 0;
        while (out_c === 16'h0002 && hc < 300) begin
            hc++;
            @(negedge clk);
        end
        tests++; if (hc !== 256) begin fails++; $display("FAIL hold256_len got=%0d exp=256", hc); end
        tests++; if (done_c !== 1'b1) begin fails++; $display("FAIL hold256_done got=%b exp=1", done_c); end
        tests++; if (ready_c !== 1'b0) begin fails++; $display("FAIL hold256_gap got=%b exp=0", ready_c); end
        @(negedge clk);
        tests++; if (ready_c !== 1'b1) begin fails++; $display("FAIL hold256_ready got=%b exp=1", ready_c); end
    endtask

    task automatic test_async_reset();
        code_a = 4'h7; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        tests++; if (out_a !== 16'h0080) begin fails++; $display("FAIL arst_pre got=%h exp=0080", out_a); end
        @(negedge clk);
        #2 rst_n = 1'b0;                // well before the next rising edge
        #1;
        tests++; if (out_a !== 16'h0000) begin fails++; $display("FAIL arst_out got=%h exp=0000", out_a); end
        tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL arst_done got=%b exp=0", done_a); end
        tests++; if (act_a !== 4'h0) begin fails++; $display("FAIL arst_active got=%h exp=0", act_a); end
        tests++; if (ready_a !== 1'b1) begin fails++; $display("FAIL arst_ready got=%b exp=1", ready_a); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        code_a = 4'h2; valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++; if (out_a !== 16'h0004) begin fails++; $display("FAIL arst_after_out[%0d] got=%h exp=0004", i, out_a); end
            @(negedge clk);
        end
        tests++; if (out_a !== 16'h0000 || done_a !== 1'b1) begin
            fails++; $display("FAIL arst_after_done out=%h done=%b exp out=0000 done=1", out_a, done_a);
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0;
        code_a = 4'h0; valid_a = 1'b0; abort_a = 1'b0;
        code_b = 4'h0; valid_b = 1'b0; abort_b = 1'b0;
        code_c = 4'h0; valid_c = 1'b0; abort_c = 1'b0;
        test_reset();
        test_single_pulse();
        test_back_to_back();
        test_code_zero();
        test_abort();
        test_gap_zero();
        test_hold_256();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decodificador_prioridade_seq.md
# decodificador_prioridade_seq

Sequential 4-to-16 one-hot decoder with a valid/ready input handshake and a timed output pulse. It is the receiving end of the 16-line priority encoder path: it takes a 4-bit priority code and drives the matching line of a 16-bit one-hot bus for a programmable number of cycles. A programmable guard gap follows each pulse, and completion is reported with a one-cycle `done` strobe. Typical use is acknowledge/select line generation for the highest-priority requester.

## Interface
- `HOLD_CYCLES`, default 4: cycles the one-hot line stays asserted; legal range 1..256.
- `GAP_CYCLES`, default 1: idle guard cycles after the pulse, before the next accept; legal range 0..256.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `code`  in  4  priority code to decode.
- `valid_in`  in  1  `code` is valid this cycle.
- `ready_in`  out  1  block can accept a code; high only in IDLE.
- `abort`  in  1  synchronous cancel of the current pulse or gap.
- `out`  out  16  registered one-hot output.
- `active_code`  out  4  code currently being driven; 0 when idle.
- `done`  out  1  one-cycle strobe at normal pulse completion.

## Operation
- Code mapping:
  - Code k (1..15) drives `out[k]` = 1, all other bits 0.
  - Code 0 means "no request". In IDLE it is accepted and discarded: no pulse, no `done`, `ready_in` stays 1.
  - `out[0]` is never driven.
- State machine:
  - States: IDLE, HOLD, GAP. Counter `cnt` is 8 bits.
  - IDLE: `ready_in` = 1, `out` = 0. On an edge with `valid_in` = 1 and `code` != 0:
    - `out` <= 1 << `code`, `active_code` <= `code`, `cnt` <= `HOLD_CYCLES` - 1, go to HOLD.
  - HOLD: `out` is held.
    - If `cnt` != 0: decrement `cnt`.
    - If `cnt` = 0: `out` <= 0, `active_code` <= 0, `done` <= 1.
    - Then, if `GAP_CYCLES` = 0: go to IDLE. Otherwise: `cnt` <= `GAP_CYCLES` - 1 and go to GAP.
  - GAP: `out` = 0. Decrement `cnt`; when `cnt` = 0, go to IDLE.
  - `done` is a registered pulse, high for exactly one cycle.
- `abort`:
  - Sampled in any state.
  - Forces IDLE, `out` = 0, `active_code` = 0, `cnt` = 0.
  - Produces no `done`.
  - Wins over an accept in the same cycle: the code is dropped even if `valid_in` is high.
- `valid_in` while `ready_in` = 0 is ignored. The upstream must hold `code`/`valid_in` until the accept edge.
- Reset (any time, including mid-HOLD or mid-GAP):
  - State IDLE, `cnt` = 0, `out` = 0, `active_code` = 0, `done` = 0.
  - `ready_in` = 1 as soon as `rst_n` is low.

## Timing
- Accept edge E0: the edge with `ready_in` = 1 and `valid_in` = 1.
- `out` is asserted from just after E0 through edge E(`HOLD_CYCLES`), i.e. exactly `HOLD_CYCLES` cycles. Zero-latency registered output.
- `done` is high in the cycle after E(`HOLD_CYCLES`), coincident with the first cycle of `out` = 0.
- `ready_in` returns high after edge E(`HOLD_CYCLES` + `GAP_CYCLES`).
- Back-to-back codes are accepted every `HOLD_CYCLES` + `GAP_CYCLES` + 1 cycles. With defaults that is every 6 cycles.
- With `GAP_CYCLES` = 0, `done` and `ready_in` are high in the same cycle.
- Counter boundary: `HOLD_CYCLES` = 256 loads `cnt` = 255. There is no wrap: `cnt` never decrements below 0.
- No combinational path from inputs to outputs. `ready_in` is decoded from registered state only.

## Test plan
- Reset then `code` = 4'hA, `valid_in` for 1 cycle (defaults):
  - `out` = 16'h0400 for exactly 4 cycles, then `done` = 1 for 1 cycle.
  - `ready_in` low 5 cycles; `active_code` = 4'hA during HOLD.
- Continuous `valid_in` cycling codes 1..15 (defaults):
  - One accept every 6 cycles, `out` = 1 << k each time, 15 `done` pulses.
  - `out[0]` never set.
- `code` = 0 with `valid_in` in IDLE: `out` stays 16'h0000, no `done`, `ready_in` stays 1.
- `code` = 4'hF accepted, `abort` on the 2nd HOLD cycle while `valid_in` = 1 with `code` = 3:
  - Next cycle `out` = 0, `ready_in` = 1, no `done`, and code 3 not accepted on the abort edge.
- `GAP_CYCLES` = 0, `HOLD_CYCLES` = 1, `code` = 5 repeated:
  - `out` = 16'h0020 for 1 cycle every 2 cycles; `done` and `ready_in` high together.
- `rst_n` driven low asynchronously mid-HOLD of `code` = 7:
  - `out` = 0, `done` = 0, `active_code` = 0, `ready_in` = 1 immediately, without waiting for a clock edge.
  - After release, the next `code` = 2 produces `out` = 16'h0004 normally.
